// File: rtl/mask_scan_encoder_pkg.sv
// ============================================================================
// mask_scan_pkg : shared state encoding and scan-direction constants
// Revision      : 1.0
// ============================================================================
`default_nettype none

package mask_scan_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic MSE_ASC  = 1'b0;
    localparam logic MSE_DESC = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mask_scan_encoder_prio_index.sv
// ============================================================================
// prio_index : combinational lowest/highest set-bit picker with one-hot select
// Revision   : 1.0
// ============================================================================
`default_nettype none

module prio_index
    import mask_scan_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] mask,
    input  logic             desc,
    output logic [IDX_W-1:0] index,
    output logic             found,
    output logic [WIDTH-1:0] onehot
);

    // The last hit in each loop wins, so loop direction is opposite to priority.
    always_comb begin
        index  = '0;
        onehot = '0;
        found  = |mask;
        if (desc == MSE_ASC) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (mask[i]) begin
                    index     = IDX_W'(i);
                    onehot    = '0;
                    onehot[i] = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (mask[i]) begin
                    index     = IDX_W'(i);
                    onehot    = '0;
                    onehot[i] = 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mask_scan_encoder.sv
// ============================================================================
// mask_scan_encoder : emits the index of every set bit of a mask, one per handshake
// Revision          : 1.0
// ============================================================================
`default_nettype none

module mask_scan_encoder
    import mask_scan_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_mask,
    input  logic             load_desc,
    input  logic             abort,
    output logic             idx_valid,
    input  logic             idx_ready,
    output logic [IDX_W-1:0] idx,
    output logic             idx_last,
    output logic [IDX_W:0]   count,
    output logic             empty,
    output logic             busy
);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] rem_nx;
    logic             desc_q;
    logic             desc_nx;
    logic [IDX_W:0]   count_q;
    logic [IDX_W:0]   count_nx;
    logic             empty_q;
    logic             empty_nx;
    logic [IDX_W:0]   load_pop;

    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;
    logic [WIDTH-1:0] sel_onehot;
    logic             rem_single;

    prio_index #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_prio_index (
        .mask   (rem),
        .desc   (desc_q),
        .index  (sel_idx),
        .found  (sel_found),
        .onehot (sel_onehot)
    );

    // Exactly one bit left: nonzero and clearing the lowest bit leaves nothing.
    assign rem_single = sel_found && ((rem & (rem - WIDTH'(1))) == '0);

    always_comb begin
        load_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            load_pop = load_pop + (IDX_W + 1)'(load_mask[i]);
        end
    end

    always_comb begin
        state_nx = state;
        rem_nx   = rem;
        desc_nx  = desc_q;
        count_nx = count_q;
        empty_nx = 1'b0;
        case (state)
            IDLE: begin
                if (load_valid) begin
                    if (|load_mask) begin
                        state_nx = SCAN;
                        rem_nx   = load_mask;
                        desc_nx  = load_desc;
                        count_nx = load_pop;
                    end else begin
                        empty_nx = 1'b1;
                    end
                end
            end
            SCAN: begin
                // Abort wins over a coincident handshake; that index is not consumed.
                if (abort) begin
                    state_nx = IDLE;
                    rem_nx   = '0;
                    count_nx = '0;
                end else if (idx_ready) begin
                    rem_nx = rem & ~sel_onehot;
                    if (rem_single) begin
                        state_nx = IDLE;
                        count_nx = '0;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                rem_nx   = '0;
                count_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state   <= IDLE;
            rem     <= '0;
            desc_q  <= MSE_ASC;
            count_q <= '0;
            empty_q <= 1'b0;
        end else begin
            state   <= state_nx;
            rem     <= rem_nx;
            desc_q  <= desc_nx;
            count_q <= count_nx;
            empty_q <= empty_nx;
        end
    end

    assign busy       = (state == SCAN);
    assign load_ready = (state == IDLE);
    assign idx_valid  = busy;
    assign idx        = busy ? sel_idx : '0;
    assign idx_last   = busy && rem_single;
    assign count      = busy ? count_q : '0;
    assign empty      = empty_q;

endmodule

`default_nettype wire

// File: tb/tb_mask_scan_encoder.sv
// ============================================================================
// tb_mask_scan_encoder : directed scoreboard bench for mask_scan_encoder
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_mask_scan_encoder;

    localparam int WIDTH = 32;
    localparam int IDX_W = 5;

    logic             clk = 1'b0;
    logic             clr_n;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_mask;
    logic             load_desc;
    logic             abort;
    logic             idx_valid;
    logic             idx_ready;
    logic [IDX_W-1:0] idx;
    logic             idx_last;
    logic [IDX_W:0]   count;
    logic             empty;
    logic             busy;

    int   vectors     = 0;
    int   miscompares = 0;
    int   q_idx[$];
    bit   q_last[$];
    int   exp_count   = 0;

    mask_scan_encoder #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_mask  (load_mask),
        .load_desc  (load_desc),
        .abort      (abort),
        .idx_valid  (idx_valid),
        .idx_ready  (idx_ready),
        .idx        (idx),
        .idx_last   (idx_last),
        .count      (count),
        .empty      (empty),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, 64'(idx_valid), 64'd0);
        chk({tag, "_idx"},   64'(idx),       64'd0);
        chk({tag, "_last"},  64'(idx_last),  64'd0);
        chk({tag, "_count"}, 64'(count),     64'd0);
        chk({tag, "_busy"},  64'(busy),      64'd0);
        chk({tag, "_ready"}, 64'(load_ready), 64'd1);
        chk({tag, "_empty"}, 64'(empty),     64'd0);
    endtask

    // Drive one load and push the expected index sequence onto the scoreboard.
    task automatic do_load(input logic [WIDTH-1:0] mask, input logic desc);
        chk("load_ready_pre", 64'(load_ready), 64'd1);
        load_valid = 1'b1;
        load_mask  = mask;
        load_desc  = desc;
        exp_count  = $countones(mask);
        for (int k = 0; k < WIDTH; k++) begin
            int b;
            b = desc ? (WIDTH - 1 - k) : k;
            if (mask[b]) begin
                q_idx.push_back(b);
                q_last.push_back(1'b0);
            end
        end
        if (q_last.size() > 0) q_last[q_last.size() - 1] = 1'b1;
        tick();
        load_valid = 1'b0;
        load_mask  = '0;
    endtask

    task automatic drain(input string tag, input int stall);
        int n;
        int cyc;
        n   = q_idx.size();
        cyc = 0;
        while (q_idx.size() > 0 && cyc < 200) begin
            idx_ready = (cyc >= stall);
            chk({tag, "_valid"}, 64'(idx_valid), 64'd1);
            chk({tag, "_busy"},  64'(busy),      64'd1);
            chk({tag, "_count"}, 64'(count),     64'(exp_count));
            chk({tag, "_lready"}, 64'(load_ready), 64'd0);
            chk({tag, "_idx"},   64'(idx),       64'(q_idx[0]));
            chk({tag, "_last"},  64'(idx_last),  64'(q_last[0]));
            if (idx_ready) begin
                void'(q_idx.pop_front());
                void'(q_last.pop_front());
            end
            tick();
            cyc++;
        end
        idx_ready = 1'b0;
        chk({tag, "_cycles"}, 64'(cyc), 64'(n + stall));
        q_idx.delete();
        q_last.delete();
        check_idle({tag, "_end"});
    endtask

    initial begin
        clr_n      = 1'b0;
        load_valid = 1'b0;
        load_mask  = '0;
        load_desc  = 1'b0;
        abort      = 1'b0;
        idx_ready  = 1'b0;
        repeat (2) tick();
        check_idle("reset");
        clr_n = 1'b1;
        tick();

        do_load(32'h8000_0011, 1'b0);
        drain("asc", 0);

        do_load(32'h8000_0011, 1'b1);
        drain("desc", 0);

        do_load(32'h0000_0006, 1'b0);
        drain("bp", 3);

        // Zero mask: one-cycle empty pulse, never valid.
        load_valid = 1'b1;
        load_mask  = '0;
        tick();
        load_valid = 1'b0;
        chk("zero_empty",  64'(empty),      64'd1);
        chk("zero_valid",  64'(idx_valid),  64'd0);
        chk("zero_lready", 64'(load_ready), 64'd1);
        tick();
        chk("zero_empty2", 64'(empty),      64'd0);
        chk("zero_valid2", 64'(idx_valid),  64'd0);

        do_load(32'hFFFF_FFFF, 1'b0);
        drain("full", 0);

        // Abort coincident with the handshake of the second index.
        do_load(32'h0000_00F0, 1'b0);
        idx_ready = 1'b1;
        chk("abort_idx0", 64'(idx), 64'd4);
        tick();
        chk("abort_idx1", 64'(idx), 64'd5);
        abort = 1'b1;
        tick();
        abort     = 1'b0;
        idx_ready = 1'b0;
        q_idx.delete();
        q_last.delete();
        check_idle("abort");
        do_load(32'h0000_0003, 1'b1);
        drain("post_abort", 0);

        // Asynchronous reset in the middle of a scan.
        do_load(32'h0000_000F, 1'b0);
        idx_ready = 1'b1;
        tick();
        idx_ready = 1'b0;
        chk("pre_rst_idx", 64'(idx), 64'd1);
        #2 clr_n = 1'b0;
        #1 check_idle("async_rst");
        q_idx.delete();
        q_last.delete();
        tick();
        chk("rst_hold_empty", 64'(empty), 64'd0);
        clr_n = 1'b1;
        tick();
        do_load(32'h0000_0001, 1'b0);
        drain("after_rst", 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
